prga_decrypt_fsm: RTL and testbench
===================================

// Module: prga_decrypt_fsm
// PURPOSE
//  RC4 PRGA/decrypt stage; consumes the S array left in s_memory by the key-schedule FSM.
//  Per byte k: i=i+1; j=j+S[i]; swap S[i],S[j]; f=S[S[i]+S[j]]; dec[k]=f^enc[k].
//  Reads ciphertext from the encrypted-message ROM and writes plaintext to the decrypted RAM.
//  Flags non-printable output so the key-search controller can reject a key early.
// PARAMETERS
//  MSG_LEN           32  bytes to decrypt (1..256); k counter is 9 bits wide
//  ABORT_ON_INVALID  1   1: stop after the first invalid byte; 0: always run MSG_LEN bytes
// PORTS
//  clk          in   1  system clock
//  reset        in   1  synchronous, active-high reset
//  start        in   1  level; sampled only in IDLE
//  finish       out  1  one-cycle pulse in DONE
//  msg_invalid  out  1  sticky until next start; set on a byte outside {0x61..0x7A, 0x20}
//  s_address    out  8  S memory address
//  s_data       out  8  S memory write data
//  s_wren       out  1  S memory write enable
//  s_q          in   8  S memory read data, 1-cycle synchronous read
//  rom_address  out  8  encrypted-message ROM address (= k)
//  rom_q        in   8  ROM read data, 1-cycle synchronous read
//  dec_address  out  8  decrypted RAM address (= k)
//  dec_data     out  8  decrypted byte
//  dec_wren     out  1  decrypted RAM write enable
// BEHAVIOUR
//  Reset: state=IDLE. All outputs and i, j, k, s_i, s_j, f are 0.
//  All memory outputs are registered.
//  Reads: capture q two cycles after the address-issue state (issue, WAIT, GET).
//  Writes: exactly one cycle with wren=1 and address/data stable. wren=0 in every other state.
//  Cleared by reset and on leaving IDLE with start=1: i, j, k, msg_invalid.
//  States and transitions:
//   IDLE (start -> INC_I)
//   INC_I (i<=i+1)
//   RD_SI -> WAIT_SI -> GET_SI (s_i<=s_q)
//   ACC_J (j<=j+s_i)
//   RD_SJ -> WAIT_SJ -> GET_SJ (s_j<=s_q)
//   WR_SI (S[i]<=s_j)
//   WR_SJ (S[j]<=s_i)
//   RD_F (s_address<=s_i+s_j, rom_address<=k) -> WAIT_F -> GET_F (f<=s_q)
//   WR_DEC (dec[k]<=f^rom_q; update msg_invalid)
//   NEXT_K
//   DONE -> IDLE
//  NEXT_K transitions:
//   -> DONE if k==MSG_LEN-1
//   -> DONE if ABORT_ON_INVALID and msg_invalid
//   -> INC_I otherwise, with k<=k+1
//  Latency: 15 cycles per byte; finish at cycle 15*N+2 after the start sample (N = bytes run).
//  Arithmetic: i, j and s_i+s_j are 8-bit modulo 256; carries are dropped.
//  i==j: the swap is a self-write; both writes still occur, with the same value.
//  i wraps 0xFF->0x00 when MSG_LEN=256; this is legal.
//  start held high: after DONE->IDLE the FSM restarts immediately with fresh i, j, k.
//  start outside IDLE: ignored.
//  Reset mid-operation: IDLE on the next edge; no further writes; finish not pulsed.
//  Reset mid-operation: S contents stay partially swapped (caller re-runs the key schedule).
// STRUCTURE
//  rc4_pkg: state enum, BYTE_W=8, ASCII_LO=8'h61, ASCII_HI=8'h7A, ASCII_SP=8'h20.
//  rc4_pkg is shared with the key-schedule FSM.
//  No sub-module: a single FSM with an inline byte-validity compare; 120-250 RTL lines.
// TESTING
//  1. Identity S, enc all 0, MSG_LEN=4, ABORT=0
//     -> dec=02,05,07,0D; final S[2]=3, S[3]=5, S[4]=9, S[5]=2, S[9]=4; finish once at cycle 62.
//  2. Identity S with S[1]=FF and S[FF]=1, enc[0]=0x61, MSG_LEN=1
//     -> j=FF; S[1]=1, S[FF]=FF; f=S[00]=0; dec[0]=0x61; msg_invalid=0.
//  3. Test-1 setup, ABORT=1
//     -> dec[0]=0x02 written, msg_invalid=1, finish at cycle 17, no dec writes to k>=1.
//  4. Reset asserted while in GET_SJ of byte 1
//     -> next cycle IDLE; all wren=0; finish never pulses.
//     -> restart from identity S reproduces test 1.
//  5. start held high across two runs -> two finish pulses; the second run starts from the swapped S.
//     Compare the second run against a software model.
//  6. Random key: key-schedule model then PRGA model, MSG_LEN=32 -> all 32 dec bytes match bit-exactly.

Source files
------------

// File: rtl/rc4_pkg.sv
// rc4_pkg -- shared definitions for the RC4 key-schedule and PRGA/decrypt FSMs.
//   prga_state_t : state encoding of the PRGA/decrypt FSM
//   BYTE_W       : datapath byte width
//   ASCII_LO/HI  : inclusive bounds of the accepted lower-case letter range
//   ASCII_SP     : the only other accepted plaintext byte (space)
package rc4_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [BYTE_W-1:0] ASCII_LO = 8'h61;
  localparam logic [BYTE_W-1:0] ASCII_HI = 8'h7A;
  localparam logic [BYTE_W-1:0] ASCII_SP = 8'h20;

  typedef enum logic [4:0] {
    ST_IDLE,
    ST_INC_I,
    ST_RD_SI,
    ST_WAIT_SI,
    ST_GET_SI,
    ST_ACC_J,
    ST_RD_SJ,
    ST_WAIT_SJ,
    ST_GET_SJ,
    ST_WR_SI,
    ST_WR_SJ,
    ST_RD_F,
    ST_WAIT_F,
    ST_GET_F,
    ST_WR_DEC,
    ST_NEXT_K,
    ST_DONE
  } prga_state_t;

endpackage

// File: rtl/prga_decrypt_fsm.sv
// prga_decrypt_fsm -- RC4 PRGA / decrypt stage.
// Walks the S array left by the key schedule, producing one keystream byte
// per message byte, XORs it with the ciphertext ROM and writes plaintext to
// the decrypted RAM. Flags any plaintext byte outside {a..z, space}.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               level request, sampled only while idle
//   finish              single-cycle completion pulse
//   msg_invalid         sticky non-printable flag, cleared on start
//   s_address/s_data/s_wren/s_q          S memory (1-cycle read latency)
//   rom_address/rom_q                    ciphertext ROM (1-cycle read latency)
//   dec_address/dec_data/dec_wren        plaintext RAM
module prga_decrypt_fsm
  import rc4_pkg::*;
#(
  parameter int unsigned MSG_LEN          = 32,
  parameter bit          ABORT_ON_INVALID = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       finish,
  output logic       msg_invalid,
  output logic [7:0] s_address,
  output logic [7:0] s_data,
  output logic       s_wren,
  input  logic [7:0] s_q,
  output logic [7:0] rom_address,
  input  logic [7:0] rom_q,
  output logic [7:0] dec_address,
  output logic [7:0] dec_data,
  output logic       dec_wren
);

  localparam logic [8:0] K_LAST = 9'(MSG_LEN - 1);

  prga_state_t       state;
  logic [7:0]        i;
  logic [7:0]        j;
  logic [8:0]        k;
  logic [7:0]        s_i;
  logic [7:0]        s_j;
  logic [7:0]        f;
  logic [7:0]        dec_byte;
  logic              byte_ok;

  // rom_q stays valid from GET_F onward because rom_address is held.
  always_comb begin
    dec_byte = f ^ rom_q;
    byte_ok  = ((dec_byte >= ASCII_LO) && (dec_byte <= ASCII_HI)) ||
               (dec_byte == ASCII_SP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      i           <= '0;
      j           <= '0;
      k           <= '0;
      s_i         <= '0;
      s_j         <= '0;
      f           <= '0;
      finish      <= 1'b0;
      msg_invalid <= 1'b0;
      s_address   <= '0;
      s_data      <= '0;
      s_wren      <= 1'b0;
      rom_address <= '0;
      dec_address <= '0;
      dec_data    <= '0;
      dec_wren    <= 1'b0;
    end else begin
      s_wren   <= 1'b0;
      dec_wren <= 1'b0;
      finish   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            i           <= '0;
            j           <= '0;
            k           <= '0;
            msg_invalid <= 1'b0;
            state       <= ST_INC_I;
          end
        end
        ST_INC_I: begin
          i     <= i + 8'd1;
          state <= ST_RD_SI;
        end
        ST_RD_SI: begin
          s_address <= i;
          state     <= ST_WAIT_SI;
        end
        ST_WAIT_SI: state <= ST_GET_SI;
        ST_GET_SI: begin
          s_i   <= s_q;
          state <= ST_ACC_J;
        end
        ST_ACC_J: begin
          j     <= j + s_i;
          state <= ST_RD_SJ;
        end
        ST_RD_SJ: begin
          s_address <= j;
          state     <= ST_WAIT_SJ;
        end
        ST_WAIT_SJ: state <= ST_GET_SJ;
        ST_GET_SJ: begin
          s_j   <= s_q;
          state <= ST_WR_SI;
        end
        // Write strobes are registered, so each write lands during the
        // following state; the S[j] write completes before the f read
        // address reaches the memory.
        ST_WR_SI: begin
          s_address <= i;
          s_data    <= s_j;
          s_wren    <= 1'b1;
          state     <= ST_WR_SJ;
        end
        ST_WR_SJ: begin
          s_address <= j;
          s_data    <= s_i;
          s_wren    <= 1'b1;
          state     <= ST_RD_F;
        end
        ST_RD_F: begin
          s_address   <= s_i + s_j;
          rom_address <= k[7:0];
          state       <= ST_WAIT_F;
        end
        ST_WAIT_F: state <= ST_GET_F;
        ST_GET_F: begin
          f     <= s_q;
          state <= ST_WR_DEC;
        end
        ST_WR_DEC: begin
          dec_address <= k[7:0];
          dec_data    <= dec_byte;
          dec_wren    <= 1'b1;
          if (!byte_ok) msg_invalid <= 1'b1;
          state <= ST_NEXT_K;
        end
        ST_NEXT_K: begin
          if ((k == K_LAST) || (ABORT_ON_INVALID && msg_invalid)) begin
            state <= ST_DONE;
          end else begin
            k     <= k + 9'd1;
            state <= ST_INC_I;
          end
        end
        ST_DONE: begin
          finish <= 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prga_decrypt_fsm.sv
// Directed bench for prga_decrypt_fsm. Four instances cover the parameter
// corners; each has its own S memory, ciphertext ROM and plaintext RAM model.
// Finish cycles are counted with the start-sampling edge as cycle 1.
module tb_prga_decrypt_fsm;

  localparam int NCFG = 4;
  localparam int LENS   [NCFG] = '{4, 4, 1, 32};
  localparam bit ABORTS [NCFG] = '{1'b0, 1'b1, 1'b0, 1'b0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start       [NCFG];
  logic       finish      [NCFG];
  logic       msg_invalid [NCFG];
  logic [7:0] s_address   [NCFG];
  logic [7:0] s_data      [NCFG];
  logic       s_wren      [NCFG];
  logic [7:0] s_q         [NCFG];
  logic [7:0] rom_address [NCFG];
  logic [7:0] rom_q       [NCFG];
  logic [7:0] dec_address [NCFG];
  logic [7:0] dec_data    [NCFG];
  logic       dec_wren    [NCFG];

  logic [7:0] s_mem   [NCFG][256];
  logic [7:0] s_init  [NCFG][256];
  logic [7:0] rom     [NCFG][256];
  logic [7:0] dec_mem [NCFG][256];
  logic       load    [NCFG];

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    prga_decrypt_fsm #(
      .MSG_LEN          (LENS[g]),
      .ABORT_ON_INVALID (ABORTS[g])
    ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start[g]),
      .finish      (finish[g]),
      .msg_invalid (msg_invalid[g]),
      .s_address   (s_address[g]),
      .s_data      (s_data[g]),
      .s_wren      (s_wren[g]),
      .s_q         (s_q[g]),
      .rom_address (rom_address[g]),
      .rom_q       (rom_q[g]),
      .dec_address (dec_address[g]),
      .dec_data    (dec_data[g]),
      .dec_wren    (dec_wren[g])
    );
  end

  // Memory models: load copies s_init into S and fills the plaintext RAM
  // with the sentinel 0xEE so unwritten locations are detectable.
  always @(posedge clk) begin
    for (int g = 0; g < NCFG; g++) begin
      if (load[g]) begin
        for (int a = 0; a < 256; a++) begin
          s_mem[g][a]   <= s_init[g][a];
          dec_mem[g][a] <= 8'hEE;
        end
      end else begin
        if (s_wren[g])   s_mem[g][s_address[g]]     <= s_data[g];
        if (dec_wren[g]) dec_mem[g][dec_address[g]] <= dec_data[g];
      end
      s_q[g]   <= s_mem[g][s_address[g]];
      rom_q[g] <= rom[g][rom_address[g]];
    end
  end

  int nvec  = 0;
  int nfail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_identity(input int g);
    for (int a = 0; a < 256; a++) s_init[g][a] = 8'(a);
  endtask

  task automatic load_s(input int g);
    @(negedge clk);
    load[g] = 1'b1;
    @(negedge clk);
    load[g] = 1'b0;
  endtask

  // Returns the cycle of the first finish pulse (0 if none within budget).
  task automatic run_wait(input int g, input bit hold, output int fin_cyc);
    @(negedge clk);
    start[g] = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start[g] = 1'b0;
    fin_cyc = 0;
    for (int c = 2; c <= 1000; c++) begin
      @(posedge clk);
      #1;
      if (finish[g]) begin
        fin_cyc = c;
        break;
      end
    end
  endtask

  // Reference RC4 keystream over a plain array, persistent across calls.
  logic [7:0] ms      [256];
  logic [7:0] exp_dec [256];
  logic       exp_inv;

  task automatic model_prga(input int g, input int n, input bit abort);
    logic [7:0] mi, mj, t, fi, b;
    mi = 8'h00;
    mj = 8'h00;
    exp_inv = 1'b0;
    for (int x = 0; x < n; x++) begin
      mi = mi + 8'd1;
      mj = mj + ms[mi];
      t = ms[mi];
      ms[mi] = ms[mj];
      ms[mj] = t;
      fi = ms[mi] + ms[mj];
      b = ms[fi] ^ rom[g][x];
      exp_dec[x] = b;
      if (!(((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20))) exp_inv = 1'b1;
      if (abort && exp_inv) break;
    end
  endtask

  function automatic int s_diff(input int g);
    int n = 0;
    for (int a = 0; a < 256; a++) if (s_mem[g][a] !== ms[a]) n++;
    return n;
  endfunction

  initial begin
    int c, c2, bad;
    logic [7:0] key [5];
    logic [7:0] kj, t;
    logic [7:0] t1_dec [4];

    t1_dec[0] = 8'h02; t1_dec[1] = 8'h05; t1_dec[2] = 8'h07; t1_dec[3] = 8'h0D;

    reset = 1'b1;
    for (int g = 0; g < NCFG; g++) begin
      start[g] = 1'b0;
      load[g]  = 1'b0;
      for (int a = 0; a < 256; a++) begin
        rom[g][a]    = 8'h00;
        s_init[g][a] = 8'(a);
      end
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst finish",      32'(finish[0]),      0);
    chk("rst msg_invalid", 32'(msg_invalid[0]), 0);
    chk("rst s_address",   32'(s_address[0]),   0);
    chk("rst s_data",      32'(s_data[0]),      0);
    chk("rst s_wren",      32'(s_wren[0]),      0);
    chk("rst rom_address", 32'(rom_address[0]), 0);
    chk("rst dec_address", 32'(dec_address[0]), 0);
    chk("rst dec_data",    32'(dec_data[0]),    0);
    chk("rst dec_wren",    32'(dec_wren[0]),    0);
    @(negedge clk);
    reset = 1'b0;

    // Test 1: identity S, zero ciphertext, 4 bytes, no abort.
    set_identity(0);
    load_s(0);
    run_wait(0, 1'b0, c);
    chk("t1 finish cycle", 32'(c), 62);
    @(posedge clk);
    #1;
    chk("t1 finish single", 32'(finish[0]), 0);
    for (int x = 0; x < 4; x++) chk($sformatf("t1 dec[%0d]", x), 32'(dec_mem[0][x]), 32'(t1_dec[x]));
    chk("t1 dec[4] untouched", 32'(dec_mem[0][4]), 32'hEE);
    chk("t1 S[2]", 32'(s_mem[0][2]), 3);
    chk("t1 S[3]", 32'(s_mem[0][3]), 5);
    chk("t1 S[4]", 32'(s_mem[0][4]), 9);
    chk("t1 S[5]", 32'(s_mem[0][5]), 2);
    chk("t1 S[9]", 32'(s_mem[0][9]), 4);
    chk("t1 msg_invalid", 32'(msg_invalid[0]), 1);

    // Test 2: j wraps to 0xFF, f index wraps to 0x00.
    set_identity(2);
    s_init[2][8'h01] = 8'hFF;
    s_init[2][8'hFF] = 8'h01;
    rom[2][0] = 8'h61;
    load_s(2);
    run_wait(2, 1'b0, c);
    chk("t2 finish cycle", 32'(c), 17);
    chk("t2 S[01]", 32'(s_mem[2][8'h01]), 8'h01);
    chk("t2 S[FF]", 32'(s_mem[2][8'hFF]), 8'hFF);
    chk("t2 S[00]", 32'(s_mem[2][8'h00]), 8'h00);
    chk("t2 dec[0]", 32'(dec_mem[2][0]), 8'h61);
    chk("t2 dec[1] untouched", 32'(dec_mem[2][1]), 32'hEE);
    chk("t2 msg_invalid", 32'(msg_invalid[2]), 0);

    // Test 3: abort after the first non-printable byte.
    set_identity(1);
    load_s(1);
    run_wait(1, 1'b0, c);
    chk("t3 finish cycle", 32'(c), 17);
    chk("t3 dec[0]", 32'(dec_mem[1][0]), 8'h02);
    chk("t3 msg_invalid", 32'(msg_invalid[1]), 1);
    for (int x = 1; x < 4; x++) chk($sformatf("t3 dec[%0d] untouched", x), 32'(dec_mem[1][x]), 32'hEE);

    // Test 4: reset while in GET_SJ of byte 1 (state after edge 23).
    set_identity(0);
    load_s(0);
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    repeat (22) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("t4 s_wren",      32'(s_wren[0]),      0);
    chk("t4 dec_wren",    32'(dec_wren[0]),    0);
    chk("t4 finish",      32'(finish[0]),      0);
    chk("t4 msg_invalid", 32'(msg_invalid[0]), 0);
    chk("t4 s_address",   32'(s_address[0]),   0);
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int x = 0; x < 40; x++) begin
      @(posedge clk);
      #1;
      if (finish[0] || s_wren[0] || dec_wren[0]) bad++;
    end
    chk("t4 quiet after reset", 32'(bad), 0);
    set_identity(0);
    load_s(0);
    run_wait(0, 1'b0, c);
    chk("t4 rerun finish cycle", 32'(c), 62);
    for (int x = 0; x < 4; x++) chk($sformatf("t4 rerun dec[%0d]", x), 32'(dec_mem[0][x]), 32'(t1_dec[x]));
    chk("t4 rerun S[9]", 32'(s_mem[0][9]), 4);

    // Test 5: start held high across two runs; second run uses swapped S.
    rom[0][0] = 8'h63; rom[0][1] = 8'h68; rom[0][2] = 8'h6C; rom[0][3] = 8'h66;
    set_identity(0);
    for (int a = 0; a < 256; a++) ms[a] = 8'(a);
    model_prga(0, 4, 1'b0);
    model_prga(0, 4, 1'b0);
    load_s(0);
    run_wait(0, 1'b1, c);
    run_wait(0, 1'b1, c2);
    @(negedge clk);
    start[0] = 1'b0;
    chk("t5 first finish cycle",  32'(c),  62);
    chk("t5 second finish cycle", 32'(c2), 62);
    for (int x = 0; x < 4; x++) chk($sformatf("t5 dec[%0d]", x), 32'(dec_mem[0][x]), 32'(exp_dec[x]));
    chk("t5 msg_invalid", 32'(msg_invalid[0]), 32'(exp_inv));
    chk("t5 S mismatches", 32'(s_diff(0)), 0);

    // Test 6: random key through a key-schedule model, then 32 bytes.
    for (int x = 0; x < 5; x++) key[x] = 8'($urandom_range(0, 255));
    for (int a = 0; a < 256; a++) ms[a] = 8'(a);
    kj = 8'h00;
    for (int a = 0; a < 256; a++) begin
      kj = kj + ms[a] + key[a % 5];
      t = ms[a];
      ms[a] = ms[kj];
      ms[kj] = t;
    end
    for (int a = 0; a < 256; a++) s_init[3][a] = ms[a];
    for (int x = 0; x < 32; x++) rom[3][x] = 8'($urandom_range(0, 255));
    model_prga(3, 32, 1'b0);
    load_s(3);
    run_wait(3, 1'b0, c);
    chk("t6 finish cycle", 32'(c), 15 * 32 + 2);
    for (int x = 0; x < 32; x++) chk($sformatf("t6 dec[%0d]", x), 32'(dec_mem[3][x]), 32'(exp_dec[x]));
    chk("t6 msg_invalid", 32'(msg_invalid[3]), 32'(exp_inv));
    chk("t6 S mismatches", 32'(s_diff(3)), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
